// File: rtl/mac_pkg.sv
// Shared types and widths for the MAC datapath.
// Operand pairs travel between feeder stages as op_pair_t.
package mac_pkg;

    localparam int OP_W      = 8;
    localparam int RESULT_W  = 22;
    localparam int VEC_CNT_W = 8;

    typedef struct packed {
        logic [OP_W-1:0] a;
        logic [OP_W-1:0] b;
    } op_pair_t;

endpackage

// File: rtl/operand_fifo.sv
// Small synchronous FIFO of operand pairs.
// Occupancy counter is one bit wider than the pointers.
module operand_fifo
    import mac_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     push,
    input  op_pair_t wdata,
    input  logic     pop,
    output op_pair_t rdata,
    output logic     full,
    output logic     empty
);

    localparam int AW = $clog2(DEPTH);

    op_pair_t        mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Storage array; written at the tail on every accepted push.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally; occupancy tracks push/pop balance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mac_operand_feeder.sv
// Feeds buffered operand pairs into the MAC one per cycle.
// Flags the cycle in which the MAC result holds a full vector sum.
module mac_operand_feeder
    import mac_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int VEC_LEN = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [OP_W-1:0]      in_a,
    input  logic [OP_W-1:0]      in_b,
    output logic                 in_ready,
    input  logic                 en,
    output logic [OP_W-1:0]      a,
    output logic [OP_W-1:0]      b,
    output logic                 active,
    output logic                 sum_valid,
    output logic [VEC_CNT_W-1:0] vec_count
);

    op_pair_t   wr_pair;
    op_pair_t   head;
    logic       full;
    logic       empty;
    logic       push;
    logic       pop;
    logic [7:0] beat;
    logic       last_issued;

    assign wr_pair  = '{a: in_a, b: in_b};
    assign in_ready = !full;
    assign push     = in_valid && in_ready;
    assign pop      = en && !empty;

    operand_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (wr_pair),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    // Issue the head pair or a zero bubble; count beats within a vector.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a           <= '0;
            b           <= '0;
            active      <= 1'b0;
            beat        <= '0;
            last_issued <= 1'b0;
        end else if (pop) begin
            a      <= head.a;
            b      <= head.b;
            active <= 1'b1;
            if (beat == 8'(VEC_LEN - 1)) begin
                beat        <= '0;
                last_issued <= 1'b1;
            end else begin
                beat        <= beat + 1'b1;
                last_issued <= 1'b0;
            end
        end else begin
            a           <= '0;
            b           <= '0;
            active      <= 1'b0;
            last_issued <= 1'b0;
        end
    end

    // Align completion with the MAC result and count finished vectors.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sum_valid <= 1'b0;
            vec_count <= '0;
        end else begin
            sum_valid <= last_issued;
            if (sum_valid) begin
                vec_count <= vec_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mac_operand_feeder.sv
// Directed bench for mac_operand_feeder with a behavioural MAC.
// The MAC accumulates a*b each edge and clears only on reset.
module tb_mac_operand_feeder;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic        in_ready;
    logic        en;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        active;
    logic        sum_valid;
    logic [7:0]  vec_count;
    logic [21:0] result;

    int total;
    int bad;

    mac_operand_feeder #(
        .DEPTH   (4),
        .VEC_LEN (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_ready  (in_ready),
        .en        (en),
        .a         (a),
        .b         (b),
        .active    (active),
        .sum_valid (sum_valid),
        .vec_count (vec_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream MAC: product of the pair driven in cycle n shows in n+1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            result <= '0;
        end else begin
            result <= result + (22'(a) * 22'(b));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        rst      = 1'b0;
        in_valid = 1'b0;
        in_a     = '0;
        in_b     = '0;
        en       = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_a", 32'(a), 0);
        chk("rst_b", 32'(b), 0);
        chk("rst_active", 32'(active), 0);
        chk("rst_sum_valid", 32'(sum_valid), 0);
        chk("rst_vec_count", 32'(vec_count), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        rst = 1'b1;

        // One vector: pairs (i+1, 2)
        en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_a     = 8'(i + 1);
            in_b     = 8'd2;
            chk("v1_in_ready", 32'(in_ready), 1);
            tick();
            if (i > 0) begin
                chk("v1_a", 32'(a), 32'(i));
                chk("v1_b", 32'(b), 2);
                chk("v1_active", 32'(active), 1);
            end
            chk("v1_no_sum", 32'(sum_valid), 0);
        end
        in_valid = 1'b0;
        tick();
        chk("v1_a8", 32'(a), 8);
        chk("v1_b8", 32'(b), 2);
        chk("v1_sum_early", 32'(sum_valid), 0);
        tick();
        chk("v1_idle", 32'(active), 0);
        chk("v1_a_zero", 32'(a), 0);
        chk("v1_sum_valid", 32'(sum_valid), 1);
        chk("v1_result", 32'(result), 72);
        chk("v1_vc_lag", 32'(vec_count), 0);
        tick();
        chk("v1_sum_pulse", 32'(sum_valid), 0);
        chk("v1_vec_count", 32'(vec_count), 1);

        // Full FIFO with en low
        en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_a     = 8'(10 + i);
            in_b     = 8'(20 + i);
            chk("full_ready", 32'(in_ready), 1);
            tick();
        end
        chk("full_drop", 32'(in_ready), 0);
        in_a = 8'd14;
        in_b = 8'd24;
        tick();
        chk("full_held", 32'(in_ready), 0);
        chk("full_no_issue", 32'(active), 0);
        en = 1'b1;
        tick();
        chk("full_pop_a", 32'(a), 10);
        chk("full_pop_b", 32'(b), 20);
        chk("full_reopen", 32'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        chk("full_a11", 32'(a), 11);
        tick();
        chk("full_a12", 32'(a), 12);
        tick();
        chk("full_a13", 32'(a), 13);
        tick();
        chk("full_a14", 32'(a), 14);
        chk("full_b24", 32'(b), 24);
        tick();
        chk("full_drained", 32'(active), 0);
        chk("full_no_sum", 32'(sum_valid), 0);

        // Bubbles: beat is at 5, three (255,255) complete the vector
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_a     = 8'd255;
            in_b     = 8'd255;
            tick();
        end
        in_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            en = (k % 2 == 0);
            tick();
            if (k % 2 == 0) begin
                chk("bub_a", 32'(a), 255);
                chk("bub_active", 32'(active), 1);
            end else begin
                chk("bub_zero_a", 32'(a), 0);
                chk("bub_zero_b", 32'(b), 0);
                chk("bub_inactive", 32'(active), 0);
            end
            chk("bub_no_sum", 32'(sum_valid), 0);
        end
        en = 1'b0;
        tick();
        chk("bub_sum_valid", 32'(sum_valid), 1);
        chk("bub_result", 32'(result), 196477);
        tick();
        chk("bub_vec_count", 32'(vec_count), 2);

        // Back-to-back vectors of (1,1)
        en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_a     = 8'd1;
            in_b     = 8'd1;
            chk("b2b_ready", 32'(in_ready), 1);
            tick();
            chk("b2b_sum", 32'(sum_valid), 32'(i == 9));
            if (i == 9) begin
                chk("b2b_result1", 32'(result), 196485);
            end
            if (i == 10) begin
                chk("b2b_vc1", 32'(vec_count), 3);
            end
        end
        in_valid = 1'b0;
        tick();
        chk("b2b_last_a", 32'(a), 1);
        chk("b2b_sum_early", 32'(sum_valid), 0);
        tick();
        chk("b2b_sum2", 32'(sum_valid), 1);
        chk("b2b_result2", 32'(result), 196493);
        tick();
        chk("b2b_vc2", 32'(vec_count), 4);

        // Reset mid-vector after five issued pairs
        en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_a     = 8'd3;
            in_b     = 8'd3;
            tick();
        end
        chk("mid_active", 32'(active), 1);
        in_valid = 1'b0;
        rst      = 1'b0;
        #1;
        chk("mid_a", 32'(a), 0);
        chk("mid_b", 32'(b), 0);
        chk("mid_active_rst", 32'(active), 0);
        chk("mid_sum_valid", 32'(sum_valid), 0);
        chk("mid_vec_count", 32'(vec_count), 0);
        chk("mid_in_ready", 32'(in_ready), 1);
        tick();
        chk("mid_result", 32'(result), 0);
        rst = 1'b1;

        // Fresh vector with push/pop at DEPTH-1 occupancy
        en = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            in_valid = 1'b1;
            in_a     = 8'(i);
            in_b     = 8'(i + 100);
            tick();
        end
        chk("d1_ready", 32'(in_ready), 1);
        en = 1'b1;
        for (int i = 4; i <= 10; i++) begin
            in_valid = 1'b1;
            in_a     = 8'(i);
            in_b     = 8'(i + 100);
            chk("d1_steady_ready", 32'(in_ready), 1);
            tick();
            chk("d1_a", 32'(a), 32'(i - 3));
            chk("d1_b", 32'(b), 32'(i - 3 + 100));
            chk("d1_active", 32'(active), 1);
            chk("d1_no_sum", 32'(sum_valid), 0);
        end
        in_valid = 1'b0;
        for (int j = 8; j <= 10; j++) begin
            tick();
            chk("d1_tail_a", 32'(a), 32'(j));
            chk("d1_tail_sum", 32'(sum_valid), 32'(j == 9));
            if (j == 9) begin
                chk("d1_result", 32'(result), 3804);
            end
        end
        chk("d1_vec_count", 32'(vec_count), 1);
        tick();
        chk("d1_empty", 32'(active), 0);
        chk("d1_ready_end", 32'(in_ready), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
